// File: rtl/fan_speed_pwm_ctrl.sv
// fan_speed_pwm_ctrl: OFF/LOW/MID/HIGH fan speed stepper with ramped PWM motor drive.
// A timer expiry (timeout falling edge) forces the fan off; OFF clears the duty at once.
module fan_speed_pwm_ctrl #(
    parameter int PRESCALE  = 50,
    parameter int PWM_STEPS = 100,
    parameter int DUTY_LOW  = 30,
    parameter int DUTY_MID  = 60,
    parameter int DUTY_HIGH = 95,
    parameter int RAMP_STEP = 1
) (
    input  logic       clk,
    input  logic       reset_p,
    input  logic       btn_speed,
    input  logic       timeout,
    output logic       fan_run,
    output logic [1:0] speed_level,
    output logic [2:0] speed_led,
    output logic [6:0] duty_cur,
    output logic       pwm_out
);
    localparam logic [1:0] S_OFF  = 2'd0;
    localparam logic [1:0] S_LOW  = 2'd1;
    localparam logic [1:0] S_MID  = 2'd2;
    localparam logic [1:0] S_HIGH = 2'd3;
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam logic [7:0] T_LOW  = 8'(DUTY_LOW  > PWM_STEPS ? PWM_STEPS : DUTY_LOW);
    localparam logic [7:0] T_MID  = 8'(DUTY_MID  > PWM_STEPS ? PWM_STEPS : DUTY_MID);
    localparam logic [7:0] T_HIGH = 8'(DUTY_HIGH > PWM_STEPS ? PWM_STEPS : DUTY_HIGH);
    localparam logic [7:0] STEP   = 8'(RAMP_STEP);

    logic          timeout_d;
    logic [PW-1:0] presc;
    logic [6:0]    pwm_cnt;
    logic          tick, boundary;
    logic [1:0]    state_nx;
    logic [2:0]    led_nx;
    logic [7:0]    tgt, duty8, up, duty_nx;

    always_comb begin
        tick     = presc == PW'(PRESCALE - 1);
        boundary = tick && pwm_cnt == 7'(PWM_STEPS - 1);
        // expiry beats a simultaneous button press
        state_nx = (timeout_d && !timeout && speed_level != S_OFF) ? S_OFF :
                   btn_speed ? speed_level + 2'd1 : speed_level;
        led_nx   = state_nx == S_LOW ? 3'b001 : state_nx == S_MID ? 3'b010 :
                   state_nx == S_HIGH ? 3'b100 : 3'b000;
        tgt      = speed_level == S_LOW ? T_LOW : speed_level == S_MID ? T_MID :
                   speed_level == S_HIGH ? T_HIGH : 8'd0;
        duty8    = {1'b0, duty_cur};
        up       = duty8 + STEP;
        duty_nx  = duty8 < tgt ? (up > tgt ? tgt : up) :
                   (duty8 - tgt > STEP ? duty8 - STEP : tgt);
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            timeout_d   <= 1'b1;
            presc       <= '0;
            pwm_cnt     <= '0;
            speed_level <= S_OFF;
            fan_run     <= 1'b0;
            speed_led   <= 3'b000;
            duty_cur    <= '0;
            pwm_out     <= 1'b0;
        end else begin
            timeout_d   <= timeout;
            presc       <= tick ? '0 : presc + PW'(1);
            if (tick)
                pwm_cnt <= pwm_cnt == 7'(PWM_STEPS - 1) ? 7'd0 : pwm_cnt + 7'd1;
            speed_level <= state_nx;
            fan_run     <= state_nx != S_OFF;
            speed_led   <= led_nx;
            duty_cur    <= speed_level == S_OFF ? 7'd0 : boundary ? duty_nx[6:0] : duty_cur;
            pwm_out     <= pwm_cnt < duty_cur;
        end
    end
endmodule

// File: tb/tb_fan_speed_pwm_ctrl.sv
// tb_fan_speed_pwm_ctrl: directed bench; expectations are queued at stimulus time and popped at sampling.
module tb_fan_speed_pwm_ctrl;
    logic       clk = 1'b0;
    logic       reset_p, btn_speed, timeout;
    logic       fan_run, pwm_out;
    logic [1:0] speed_level;
    logic [2:0] speed_led;
    logic [6:0] duty_cur;

    typedef struct {string tag; int val;} exp_t;
    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    fan_speed_pwm_ctrl #(
        .PRESCALE(2), .PWM_STEPS(10), .DUTY_LOW(3), .DUTY_MID(6), .DUTY_HIGH(9), .RAMP_STEP(1)
    ) dut (
        .clk(clk), .reset_p(reset_p), .btn_speed(btn_speed), .timeout(timeout),
        .fan_run(fan_run), .speed_level(speed_level), .speed_led(speed_led),
        .duty_cur(duty_cur), .pwm_out(pwm_out)
    );

    always #5 clk = ~clk;

    task automatic push(input string tag, input int val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic chk(input int obs);
        exp_t e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $error("FAIL scoreboard_empty: got %0d expected an entry", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val) else begin
                n_err++;
                $error("FAIL %s: got %0d expected %0d", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse;
        btn_speed = 1'b1;
        cyc(1);
        btn_speed = 1'b0;
    endtask

    task automatic wait_duty(input int val, input int max, input string tag);
        for (int i = 0; i < max && int'(duty_cur) != val; i++) cyc(1);
        push(tag, val);
        chk(int'(duty_cur));
    endtask

    task automatic chk_state(input string tag, input int lvl);
        push({tag, "_level"}, lvl);
        chk(int'(speed_level));
        push({tag, "_run"}, lvl != 0 ? 1 : 0);
        chk(int'(fan_run));
        push({tag, "_led"}, lvl == 0 ? 0 : 1 << (lvl - 1));
        chk(int'(speed_led));
    endtask

    task automatic idle_check(input string tag, input int n);
        chk_state(tag, 0);
        push({tag, "_duty"}, 0);
        chk(int'(duty_cur));
        for (int i = 0; i < n; i++) begin
            cyc(1);
            push({tag, "_pwm"}, 0);
            chk(int'(pwm_out));
        end
    endtask

    initial begin
        int highs;
        reset_p = 1'b1;
        btn_speed = 1'b0;
        timeout = 1'b1;
        cyc(2);
        reset_p = 1'b0;
        idle_check("t1", 100);

        pulse;
        chk_state("t2", 1);
        wait_duty(1, 40, "t2_duty1");
        cyc(19);
        push("t2_hold1", 1);
        chk(int'(duty_cur));
        cyc(1);
        push("t2_duty2", 2);
        chk(int'(duty_cur));
        cyc(20);
        push("t2_duty3", 3);
        chk(int'(duty_cur));
        cyc(60);
        push("t2_sat3", 3);
        chk(int'(duty_cur));
        highs = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            highs += int'(pwm_out);
        end
        push("t2_pwm_high_cycles", 6);
        chk(highs);

        pulse;
        pulse;
        chk_state("t3_high", 3);
        wait_duty(9, 160, "t3_duty9");
        cyc(45);
        push("t3_sat9", 9);
        chk(int'(duty_cur));
        pulse;
        chk_state("t3_off", 0);
        cyc(1);
        push("t3_duty0", 0);
        chk(int'(duty_cur));
        cyc(1);
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            push("t3_pwm0", 0);
            chk(int'(pwm_out));
        end

        pulse;
        pulse;
        chk_state("t4_mid", 2);
        wait_duty(6, 160, "t4_duty6");
        timeout = 1'b0;
        cyc(1);
        chk_state("t4_expired", 0);
        cyc(1);
        push("t4_duty0", 0);
        chk(int'(duty_cur));
        cyc(5);
        pulse;
        chk_state("t4_restart", 1);
        wait_duty(1, 40, "t4_ramp1");

        timeout = 1'b1;
        cyc(2);
        timeout = 1'b0;
        btn_speed = 1'b1;
        cyc(1);
        btn_speed = 1'b0;
        chk_state("t5_tie", 0);

        timeout = 1'b1;
        cyc(2);
        pulse;
        pulse;
        pulse;
        chk_state("t6_high", 3);
        wait_duty(5, 200, "t6_duty5");
        #2 reset_p = 1'b1;
        #1;
        chk_state("t6_async", 0);
        push("t6_async_duty", 0);
        chk(int'(duty_cur));
        push("t6_async_pwm", 0);
        chk(int'(pwm_out));
        cyc(2);
        reset_p = 1'b0;
        idle_check("t6_after", 40);
        pulse;
        chk_state("t6_relaunch", 1);
        wait_duty(1, 40, "t6_ramp1");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
